// File: rtl/mem_lsu_pkg.sv
// rtl/mem_lsu_pkg.sv - Shared opcodes, bus types and FSM states for the MEM stage
package mem_lsu_pkg;

    typedef logic [7:0]  alu_op_bus_t;
    typedef logic [31:0] reg_bus_t;
    typedef logic [4:0]  reg_addr_bus_t;

    localparam logic WRITE_DISABLE = 1'b0;

    localparam alu_op_bus_t EXE_LB_OP  = 8'b1110_0000;
    localparam alu_op_bus_t EXE_LH_OP  = 8'b1110_0001;
    localparam alu_op_bus_t EXE_LW_OP  = 8'b1110_0011;
    localparam alu_op_bus_t EXE_LBU_OP = 8'b1110_0100;
    localparam alu_op_bus_t EXE_LHU_OP = 8'b1110_0101;
    localparam alu_op_bus_t EXE_SB_OP  = 8'b1110_1000;
    localparam alu_op_bus_t EXE_SH_OP  = 8'b1110_1001;
    localparam alu_op_bus_t EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    function automatic logic is_load_op(input alu_op_bus_t op);
        return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
    endfunction

    function automatic logic is_store_op(input alu_op_bus_t op);
        return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    endfunction

endpackage

// File: rtl/mem_bus_fsm.sv
// rtl/mem_bus_fsm.sv - Bus access sequencer: IDLE/BUSY/DONE, ack timeout, registered bus outputs
module mem_bus_fsm
    import mem_lsu_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16,
    parameter int AW          = 32
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          start,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [3:0]    req_sel,
    input  logic [31:0]   req_wdata,
    input  logic          bus_ack,
    input  logic [31:0]   bus_rdata,
    output lsu_state_e    state,
    output logic [31:0]   rdata,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [3:0]    bus_sel,
    output logic [31:0]   bus_wdata,
    output logic          bus_err
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    lsu_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d, we_q, we_d, err_q, err_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    sel_q, sel_d;
    logic [31:0]   wdata_q, wdata_d, rdata_q, rdata_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d = ST_BUSY;
                cnt_d   = '0;
                req_d   = 1'b1;
                we_d    = req_we;
                addr_d  = req_addr;
                sel_d   = req_sel;
                wdata_d = req_wdata;
            end
            ST_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                // An ack arriving on the final allowed cycle still completes normally.
                if (bus_ack) begin
                    rdata_d = bus_rdata;
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            sel_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign state     = state_q;
    assign rdata     = rdata_q;
    assign bus_req   = req_q;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_sel   = sel_q;
    assign bus_wdata = wdata_q;
    assign bus_err   = err_q;

endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MEM stage load/store unit, big-endian lanes; MEM_ALIGN_CHK_EN adds alignment exceptions
module mem_lsu #(
    parameter int ACK_TIMEOUT = 16,
    parameter int AW          = 32
) (
    input  logic          clk,
    input  logic          clr,
    input  logic [4:0]    mem_wd,
    input  logic          mem_wreg,
    input  logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_hi,
    input  logic [31:0]   mem_lo,
    input  logic          mem_whilo,
    input  logic [7:0]    mem_aluop,
    input  logic [31:0]   mem_mem_addr,
    input  logic [31:0]   mem_reg2,
    output logic [4:0]    wb_wd,
    output logic          wb_wreg,
    output logic [31:0]   wb_wdata,
    output logic [31:0]   wb_hi,
    output logic [31:0]   wb_lo,
    output logic          wb_whilo,
    output logic          stallreq,
`ifdef MEM_ALIGN_CHK_EN
    output logic          excp_adel,
    output logic          excp_ades,
`endif
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [3:0]    bus_sel,
    output logic [31:0]   bus_wdata,
    input  logic [31:0]   bus_rdata,
    input  logic          bus_ack,
    output logic          bus_err
);
    import mem_lsu_pkg::*;

    lsu_state_e  state;
    logic [31:0] rdata, st_data, ld_data;
    logic [3:0]  sel;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        is_st, is_mem, align_bad, start;

    assign is_st  = is_store_op(mem_aluop);
    assign is_mem = is_load_op(mem_aluop) | is_st;

    always_comb begin
        sel     = 4'b0000;
        st_data = mem_reg2;
        case (mem_aluop)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: begin
                sel     = 4'b1000 >> mem_mem_addr[1:0];
                st_data = {4{mem_reg2[7:0]}};
            end
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: begin
                sel     = mem_mem_addr[1] ? 4'b0011 : 4'b1100;
                st_data = {2{mem_reg2[15:0]}};
            end
            EXE_LW_OP, EXE_SW_OP: sel = 4'b1111;
            default: ;
        endcase
    end

    always_comb begin
        case (mem_mem_addr[1:0])
            2'd0:    ld_byte = rdata[31:24];
            2'd1:    ld_byte = rdata[23:16];
            2'd2:    ld_byte = rdata[15:8];
            default: ld_byte = rdata[7:0];
        endcase
        ld_half = mem_mem_addr[1] ? rdata[15:0] : rdata[31:16];
        case (mem_aluop)
            EXE_LB_OP:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            EXE_LBU_OP: ld_data = {24'd0, ld_byte};
            EXE_LH_OP:  ld_data = {{16{ld_half[15]}}, ld_half};
            EXE_LHU_OP: ld_data = {16'd0, ld_half};
            EXE_LW_OP:  ld_data = rdata;
            default:    ld_data = mem_wdata;
        endcase
    end

`ifdef MEM_ALIGN_CHK_EN
    always_comb begin
        excp_adel = 1'b0;
        excp_ades = 1'b0;
        if (state == ST_IDLE) begin
            case (mem_aluop)
                EXE_LH_OP, EXE_LHU_OP: excp_adel = mem_mem_addr[0];
                EXE_LW_OP:             excp_adel = |mem_mem_addr[1:0];
                EXE_SH_OP:             excp_ades = mem_mem_addr[0];
                EXE_SW_OP:             excp_ades = |mem_mem_addr[1:0];
                default: ;
            endcase
        end
    end
    assign align_bad = excp_adel | excp_ades;
`else
    assign align_bad = 1'b0;
`endif

    // DONE is the single cycle the held instruction is allowed to retire.
    assign stallreq = is_mem & ~align_bad & (state != ST_DONE);
    assign start    = is_mem & ~align_bad & (state == ST_IDLE);

    always_comb begin
        wb_wd    = mem_wd;
        wb_hi    = mem_hi;
        wb_lo    = mem_lo;
        wb_wreg  = mem_wreg;
        wb_whilo = mem_whilo;
        wb_wdata = mem_wdata;
        if (is_mem) begin
            wb_wdata = ld_data;
            if (is_st || align_bad) wb_wreg = WRITE_DISABLE;
        end
        if (stallreq) begin
            wb_wreg  = WRITE_DISABLE;
            wb_whilo = WRITE_DISABLE;
        end
    end

    mem_bus_fsm #(
        .ACK_TIMEOUT(ACK_TIMEOUT),
        .AW         (AW)
    ) u_fsm (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .req_we    (is_st),
        .req_addr  ({mem_mem_addr[AW-1:2], 2'b00}),
        .req_sel   (sel),
        .req_wdata (st_data),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata),
        .state     (state),
        .rdata     (rdata),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_sel   (bus_sel),
        .bus_wdata (bus_wdata),
        .bus_err   (bus_err)
    );

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - Self-checking bench for mem_lsu: directed loads/stores, timeout, clear, alignment
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    localparam int ACK_TIMEOUT = 16;
    localparam logic [7:0] OP_ADDU = 8'b0010_0001;
`ifdef MEM_ALIGN_CHK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr;
    logic [4:0]  mem_wd;
    logic        mem_wreg, mem_whilo;
    logic [31:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2;
    logic [7:0]  mem_aluop;
    logic [4:0]  wb_wd;
    logic        wb_wreg, wb_whilo, stallreq;
    logic [31:0] wb_wdata, wb_hi, wb_lo;
    logic        bus_req, bus_we, bus_ack, bus_err;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_sel;
`ifdef MEM_ALIGN_CHK_EN
    logic        excp_adel, excp_ades;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    logic [31:0] resp_data = '0;
    int          ack_delay = -1;
    int          late_ack_cyc = -1;
    logic [31:0] exp_rdata = '0;
    int          cyc = 0;

    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_sel;
    logic        cap_we, cap_valid;

    always #5 clk = ~clk;

    mem_lsu #(.ACK_TIMEOUT(ACK_TIMEOUT), .AW(32)) dut (
        .clk(clk), .clr(clr),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
        .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo),
        .stallreq(stallreq),
`ifdef MEM_ALIGN_CHK_EN
        .excp_adel(excp_adel), .excp_ades(excp_ades),
`endif
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Access size in bytes, 0 for non-memory ops.
    function automatic int m_size(input logic [7:0] op);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return 1;
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return 2;
            EXE_LW_OP, EXE_SW_OP:             return 4;
            default:                          return 0;
        endcase
    endfunction

    function automatic bit m_store(input logic [7:0] op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
    endfunction

    function automatic int m_off(input int sz, input logic [31:0] a);
        return (sz == 4) ? 0 : int'(a[1:0]) & ~(sz - 1);
    endfunction

    function automatic logic [3:0] m_sel(input logic [7:0] op, input logic [31:0] a);
        int sz;
        logic [3:0] ones;
        sz   = m_size(op);
        ones = 4'((1 << sz) - 1);
        return 4'(ones << (4 - sz - m_off(sz, a)));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] r);
        int sz;
        sz = m_size(op);
        if (sz == 1) return (r & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (r & 32'hFFFF) * 32'h0001_0001;
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
        int sz;
        logic [31:0] v;
        sz = m_size(op);
        v  = d >> (8 * (4 - sz - m_off(sz, a)));
        if (sz == 1) begin
            v = v & 32'hFF;
            if (op == EXE_LB_OP && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = v & 32'hFFFF;
            if (op == EXE_LH_OP && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    // Bus slave: ack on the ack_delay-th cycle of a request (0 = first), or never when negative.
    initial begin
        int age;
        age       = 0;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            bus_ack = 1'b0;
            if (cyc == late_ack_cyc) begin
                bus_ack   = 1'b1;
                bus_rdata = 32'h5A5A_5A5A;
            end
            if (bus_req && !clr) begin
                if (age == ack_delay) begin
                    bus_ack   = 1'b1;
                    bus_rdata = resp_data;
                end
                age++;
            end else begin
                age = 0;
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        int sz;
        bit st, mis;
        forever begin
            @(negedge clk);
            if (chk_en && !clr) begin
                sz  = m_size(mem_aluop);
                st  = m_store(mem_aluop);
                mis = ALIGN_CHK && sz > 1 && ((mem_mem_addr & 32'(sz - 1)) != 0);
                check("wb_wd", 32'(wb_wd), 32'(mem_wd));
                check("wb_hi", wb_hi, mem_hi);
                check("wb_lo", wb_lo, mem_lo);
`ifdef MEM_ALIGN_CHK_EN
                check("excp_adel", 32'(excp_adel), 32'(mis && !st));
                check("excp_ades", 32'(excp_ades), 32'(mis && st));
`endif
                if (sz == 0) begin
                    check("pass_wdata", wb_wdata, mem_wdata);
                    check("pass_wreg", 32'(wb_wreg), 32'(mem_wreg));
                    check("pass_whilo", 32'(wb_whilo), 32'(mem_whilo));
                    check("pass_stall", 32'(stallreq), 32'd0);
                    check("pass_busreq", 32'(bus_req), 32'd0);
                end else if (mis) begin
                    check("mis_stall", 32'(stallreq), 32'd0);
                    check("mis_busreq", 32'(bus_req), 32'd0);
                    check("mis_wreg", 32'(wb_wreg), 32'd0);
                end else if (stallreq) begin
                    check("bubble_wreg", 32'(wb_wreg), 32'd0);
                    check("bubble_whilo", 32'(wb_whilo), 32'd0);
                    if (bus_req) begin
                        check("bus_addr", bus_addr, mem_mem_addr & 32'hFFFF_FFFC);
                        check("bus_sel", 32'(bus_sel), 32'(m_sel(mem_aluop, mem_mem_addr)));
                        check("bus_we", 32'(bus_we), 32'(st));
                        if (st) check("bus_wdata", bus_wdata, m_wdata(mem_aluop, mem_reg2));
                    end
                end else begin
                    check("done_wreg", 32'(wb_wreg), st ? 32'd0 : 32'(mem_wreg));
                    check("done_whilo", 32'(wb_whilo), 32'(mem_whilo));
                    if (!st) check("done_wdata", wb_wdata, m_load(mem_aluop, mem_mem_addr, exp_rdata));
                end
            end
        end
    end

    task automatic drive_nop(input logic [31:0] wdata);
        mem_aluop    = OP_ADDU;
        mem_wdata    = wdata;
        mem_wd       = 5'd9;
        mem_wreg     = 1'b1;
        mem_whilo    = 1'b1;
        mem_mem_addr = '0;
        mem_reg2     = '0;
    endtask

    task automatic run_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                           input logic [31:0] rdata, input int delay,
                           output int stalls, output int reqs, output int errs,
                           output logic [31:0] wdata_out, output logic wreg_out);
        @(posedge clk);
        #1;
        mem_aluop    = op;
        mem_mem_addr = addr;
        mem_reg2     = reg2;
        mem_wdata    = 32'hCAFE_0000 ^ addr;
        mem_wd       = addr[4:0];
        mem_wreg     = 1'b1;
        mem_whilo    = addr[2];
        resp_data    = rdata;
        ack_delay    = delay;
        exp_rdata    = (delay < 0 || delay >= ACK_TIMEOUT) ? 32'd0 : rdata;
        stalls = 0; reqs = 0; errs = 0;
        cap_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus_req) begin
                reqs++;
                if (!cap_valid) begin
                    cap_valid = 1'b1;
                    cap_addr  = bus_addr;
                    cap_sel   = bus_sel;
                    cap_we    = bus_we;
                    cap_wdata = bus_wdata;
                end
            end
            if (bus_err) errs++;
            if (!stallreq) break;
            stalls++;
        end
        wdata_out = wb_wdata;
        wreg_out  = wb_wreg;
        @(posedge clk);
        #1;
        drive_nop(32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int st, rq, er;
        logic [31:0] wd;
        logic wr;
        clr = 1'b1;
        mem_hi = 32'h1111_2222;
        mem_lo = 32'h3333_4444;
        drive_nop(32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_sel", 32'(bus_sel), 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        @(posedge clk);
        #1;
        clr    = 1'b0;
        chk_en = 1'b1;

        drive_nop(32'h0000_1234);
        @(negedge clk);
        check("addu_wdata", wb_wdata, 32'h0000_1234);
        check("addu_stall", 32'(stallreq), 32'd0);
        check("addu_busreq", 32'(bus_req), 32'd0);

        run_mem(EXE_LB_OP, 32'h103, 32'h0, 32'h0000_00F0, 0, st, rq, er, wd, wr);
        check("lb_stalls", 32'(st), 32'd2);
        check("lb_sel", 32'(cap_sel), 32'b0001);
        check("lb_addr", cap_addr, 32'h100);
        check("lb_wdata", wd, 32'hFFFF_FFF0);

        run_mem(EXE_LBU_OP, 32'h103, 32'h0, 32'h0000_00F0, 0, st, rq, er, wd, wr);
        check("lbu_wdata", wd, 32'h0000_00F0);

        run_mem(EXE_SH_OP, 32'h202, 32'hAAAA_BEEF, 32'h0, 0, st, rq, er, wd, wr);
        check("sh_we", 32'(cap_we), 32'd1);
        check("sh_sel", 32'(cap_sel), 32'b0011);
        check("sh_bus_wdata", cap_wdata, 32'hBEEF_BEEF);
        check("sh_wreg", 32'(wr), 32'd0);

        run_mem(EXE_SB_OP, 32'h001, 32'h0000_0055, 32'h0, 0, st, rq, er, wd, wr);
        check("sb_sel", 32'(cap_sel), 32'b0100);
        check("sb_bus_wdata", cap_wdata, 32'h5555_5555);

        run_mem(EXE_LH_OP, 32'h102, 32'h0, 32'h1234_8001, 2, st, rq, er, wd, wr);
        check("lh_stalls", 32'(st), 32'd4);
        check("lh_wdata", wd, 32'hFFFF_8001);

        run_mem(EXE_LHU_OP, 32'h100, 32'h0, 32'h8001_0000, 1, st, rq, er, wd, wr);
        check("lhu_wdata", wd, 32'h0000_8001);

        run_mem(EXE_LW_OP, 32'h010, 32'h0, 32'h7777_7777, -1, st, rq, er, wd, wr);
        check("tmo_reqs", 32'(rq), 32'd16);
        check("tmo_err", 32'(er), 32'd1);
        check("tmo_stalls", 32'(st), 32'd17);
        check("tmo_wdata", wd, 32'd0);

        run_mem(EXE_LW_OP, 32'h014, 32'h0, 32'hDEAD_BEEF, 15, st, rq, er, wd, wr);
        check("lastack_err", 32'(er), 32'd0);
        check("lastack_reqs", 32'(rq), 32'd16);
        check("lastack_wdata", wd, 32'hDEAD_BEEF);

        @(posedge clk);
        #1;
        mem_aluop    = EXE_LW_OP;
        mem_mem_addr = 32'h500;
        ack_delay    = -1;
        repeat (4) @(negedge clk);
        check("pre_clr_req", 32'(bus_req), 32'd1);
        @(posedge clk);
        #1;
        clr = 1'b1;
        drive_nop(32'h0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        late_ack_cyc = cyc + 1;
        @(negedge clk);
        check("clr_req", 32'(bus_req), 32'd0);
        check("clr_stall", 32'(stallreq), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("late_ack_req", 32'(bus_req), 32'd0);
        end

        run_mem(EXE_SW_OP, 32'h400, 32'h1122_3344, 32'h0, 1, st, rq, er, wd, wr);
        check("sw_stalls", 32'(st), 32'd3);
        check("sw_sel", 32'(cap_sel), 32'b1111);
        check("sw_addr", cap_addr, 32'h400);
        check("sw_bus_wdata", cap_wdata, 32'h1122_3344);

`ifdef MEM_ALIGN_CHK_EN
        @(posedge clk);
        #1;
        mem_aluop    = EXE_LW_OP;
        mem_mem_addr = 32'h302;
        repeat (2) begin
            @(negedge clk);
            check("adel_flag", 32'(excp_adel), 32'd1);
            check("adel_busreq", 32'(bus_req), 32'd0);
            check("adel_stall", 32'(stallreq), 32'd0);
        end
        @(posedge clk);
        #1;
        drive_nop(32'h0);
`endif

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
